// File: rtl/fastlock_hop_scheduler.sv
// Fast-lock profile hop scheduler: walks a programmable 8-entry hop table with
// per-hop settle/dwell timing and arbitrates one manual override requester.
module fastlock_hop_scheduler #(
    parameter int unsigned PROFILE_SHIFT = 9,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [2:0]       cfg_profile,
    input  logic [2:0]       cfg_len,
    input  logic [CNT_W-1:0] dwell_cycles,
    input  logic [CNT_W-1:0] settle_cycles,
    input  logic             enable,
    input  logic             ovr_req,
    input  logic [2:0]       ovr_profile,
    output logic             ovr_ack,
    output logic [63:0]      gpio_o,
    output logic [2:0]       profile_o,
    output logic             hop_o,
    output logic             settled_o,
    output logic [2:0]       hop_index_o,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_DWELL,
        S_OVR_SETTLE,
        S_OVR_HOLD,
        S_OVR_REL
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_tbl [8];
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_profile;
    logic [2:0]       w_profile_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [2:0]       w_idx_adv;
    logic             r_hop;
    logic             w_hop_nxt;
    logic             w_bnd;
    logic [2:0]       w_bnd_idx;
    logic [CNT_W-1:0] w_settle_ld;
    logic [CNT_W-1:0] w_dwell_ld;

    // A zero count is treated as one cycle, so the load value is max(n,1)-1.
    assign w_settle_ld = (settle_cycles == '0) ? '0 : settle_cycles - CNT_W'(1);
    assign w_dwell_ld  = (dwell_cycles  == '0) ? '0 : dwell_cycles  - CNT_W'(1);
    assign w_idx_adv   = (r_idx >= cfg_len) ? '0 : r_idx + 3'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < 8; i++) begin
                r_tbl[i] <= '0;
            end
        end else if (cfg_we) begin
            r_tbl[cfg_addr] <= cfg_profile;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_profile <= '0;
            r_idx     <= '0;
            r_hop     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_profile <= w_profile_nxt;
            r_idx     <= w_idx_nxt;
            r_hop     <= w_hop_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_profile_nxt = r_profile;
        w_idx_nxt     = r_idx;
        w_hop_nxt     = 1'b0;
        w_bnd         = 1'b0;
        w_bnd_idx     = r_idx;

        unique case (r_state)
            S_IDLE: begin
                w_bnd = 1'b1;
            end
            S_SETTLE, S_OVR_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = (r_state == S_SETTLE) ? S_DWELL : S_OVR_HOLD;
                    w_cnt_nxt   = w_dwell_ld;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_DWELL: begin
                if (r_cnt == '0) begin
                    w_idx_nxt = w_idx_adv;
                    w_bnd     = 1'b1;
                    w_bnd_idx = w_idx_adv;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_OVR_HOLD: begin
                if (!ovr_req) begin
                    w_state_nxt = S_OVR_REL;
                end
            end
            S_OVR_REL: begin
                w_bnd = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Hop boundary arbitration: override first, then the schedule, else park.
        if (w_bnd) begin
            if (ovr_req) begin
                w_state_nxt   = S_OVR_SETTLE;
                w_profile_nxt = ovr_profile;
                w_cnt_nxt     = w_settle_ld;
                w_hop_nxt     = 1'b1;
            end else if (enable) begin
                w_state_nxt   = S_SETTLE;
                w_profile_nxt = r_tbl[w_bnd_idx];
                w_cnt_nxt     = w_settle_ld;
                w_hop_nxt     = 1'b1;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    assign profile_o   = r_profile;
    assign gpio_o      = {61'b0, r_profile} << PROFILE_SHIFT;
    assign hop_o       = r_hop;
    assign hop_index_o = r_idx;
    assign settled_o   = (r_state == S_DWELL) || (r_state == S_OVR_HOLD);
    assign ovr_ack     = (r_state == S_OVR_HOLD);
    assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_fastlock_hop_scheduler.sv
// Directed and randomized checks of fastlock_hop_scheduler against a timeline
// model: cycle c of a run falls in hop (c-1)/(settle+dwell) at phase (c-1)%(settle+dwell).
module tb_fastlock_hop_scheduler;

    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             cfg_we = 1'b0;
    logic [2:0]       cfg_addr = '0;
    logic [2:0]       cfg_profile = '0;
    logic [2:0]       cfg_len = '0;
    logic [CNT_W-1:0] dwell_cycles = '0;
    logic [CNT_W-1:0] settle_cycles = '0;
    logic             enable = 1'b0;
    logic             ovr_req = 1'b0;
    logic [2:0]       ovr_profile = '0;
    logic             ovr_ack;
    logic [63:0]      gpio_o;
    logic [2:0]       profile_o;
    logic             hop_o;
    logic             settled_o;
    logic [2:0]       hop_index_o;
    logic             busy_o;

    fastlock_hop_scheduler #(.PROFILE_SHIFT(9), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_profile(cfg_profile), .cfg_len(cfg_len), .dwell_cycles(dwell_cycles),
        .settle_cycles(settle_cycles), .enable(enable), .ovr_req(ovr_req),
        .ovr_profile(ovr_profile), .ovr_ack(ovr_ack), .gpio_o(gpio_o),
        .profile_o(profile_o), .hop_o(hop_o), .settled_o(settled_o),
        .hop_index_o(hop_index_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [2:0] m_tbl [8];
    int         m_len, m_s, m_d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_sched(input int c);
        int per, h, p;
        logic [2:0] idx;
        per = m_s + m_d;
        h   = (c - 1) / per;
        p   = (c - 1) % per;
        idx = 3'(h % (m_len + 1));
        chk("profile",   64'(profile_o),   64'(m_tbl[idx]));
        chk("gpio",      gpio_o,           64'(m_tbl[idx]) << 9);
        chk("hop",       64'(hop_o),       (p == 0) ? 64'd1 : 64'd0);
        chk("settled",   64'(settled_o),   (p >= m_s) ? 64'd1 : 64'd0);
        chk("hop_index", 64'(hop_index_o), 64'(idx));
        chk("busy",      64'(busy_o),      64'd1);
        chk("ovr_ack",   64'(ovr_ack),     64'd0);
    endtask

    task automatic chk_idle(input string tag, input logic [2:0] prof, input logic [2:0] idx);
        chk({tag, "_profile"}, 64'(profile_o),   64'(prof));
        chk({tag, "_gpio"},    gpio_o,           64'(prof) << 9);
        chk({tag, "_idx"},     64'(hop_index_o), 64'(idx));
        chk({tag, "_busy"},    64'(busy_o),      64'd0);
        chk({tag, "_settled"}, 64'(settled_o),   64'd0);
        chk({tag, "_hop"},     64'(hop_o),       64'd0);
        chk({tag, "_ack"},     64'(ovr_ack),     64'd0);
    endtask

    task automatic chk_ovr(input logic hop, input logic settled, input logic ack);
        chk("ovr_profile", 64'(profile_o),   64'd6);
        chk("ovr_gpio",    gpio_o,           64'd6 << 9);
        chk("ovr_idx",     64'(hop_index_o), 64'd2);
        chk("ovr_busy",    64'(busy_o),      64'd1);
        chk("ovr_hop",     64'(hop_o),       64'(hop));
        chk("ovr_settled", 64'(settled_o),   64'(settled));
        chk("ovr_ackval",  64'(ovr_ack),     64'(ack));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetn  = 1'b0;
        enable  = 1'b0;
        ovr_req = 1'b0;
        cfg_we  = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cyc    = 0;
        chk_idle("reset", 3'd0, 3'd0);
    endtask

    task automatic wr(input int a, input int v);
        cfg_we      = 1'b1;
        cfg_addr    = 3'(a);
        cfg_profile = 3'(v);
        step();
        cfg_we = 1'b0;
    endtask

    // Loads m_tbl into the DUT and applies length/timing; leaves enable low.
    task automatic setup(input int len, input int s, input int d);
        for (int i = 0; i < 8; i++) wr(i, int'(m_tbl[i]));
        m_len         = len;
        cfg_len       = 3'(len);
        settle_cycles = CNT_W'(s);
        dwell_cycles  = CNT_W'(d);
        m_s           = (s == 0) ? 1 : s;
        m_d           = (d == 0) ? 1 : d;
    endtask

    task automatic start();
        enable = 1'b1;
        cyc    = 0;
    endtask

    task automatic set_tbl351();
        for (int i = 0; i < 8; i++) m_tbl[i] = 3'd0;
        m_tbl[0] = 3'd3;
        m_tbl[1] = 3'd5;
        m_tbl[2] = 3'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Table {3,5,1}, settle 4, dwell 10: 14-cycle hops.
        set_tbl351();
        setup(2, 4, 10);
        start();
        for (int c = 1; c <= 45; c++) begin
            step();
            chk_sched(cyc);
        end

        // settle=0, dwell=0 behave as 1 cycle each.
        do_reset();
        setup(2, 0, 0);
        start();
        for (int c = 1; c <= 12; c++) begin
            step();
            chk_sched(cyc);
        end

        // Randomized tables, lengths and timings.
        for (int r = 0; r < 6; r++) begin
            int len, s, d, n;
            do_reset();
            for (int i = 0; i < 8; i++) m_tbl[i] = 3'($urandom_range(7, 0));
            len = int'($urandom_range(7, 0));
            s   = int'($urandom_range(4, 0));
            d   = int'($urandom_range(5, 0));
            setup(len, s, d);
            n = 2 * (len + 1) * (m_s + m_d) + 3;
            if (n > 60) n = 60;
            start();
            for (int c = 1; c <= n; c++) begin
                step();
                chk_sched(cyc);
            end
        end

        // Override requested mid-DWELL of index 1; granted at the hop boundary.
        do_reset();
        set_tbl351();
        setup(2, 4, 10);
        start();
        for (int c = 1; c <= 20; c++) begin
            step();
            chk_sched(cyc);
        end
        ovr_profile = 3'd6;
        ovr_req     = 1'b1;
        for (int c = 21; c <= 28; c++) begin
            step();
            chk_sched(cyc);
        end
        step();
        chk_ovr(1'b1, 1'b0, 1'b0);
        for (int c = 30; c <= 32; c++) begin
            step();
            chk_ovr(1'b0, 1'b0, 1'b0);
        end
        for (int c = 33; c <= 36; c++) begin
            step();
            chk_ovr(1'b0, 1'b1, 1'b1);
        end
        ovr_req = 1'b0;
        step();
        chk_ovr(1'b0, 1'b0, 1'b0);
        // Schedule resumes at index 2, i.e. nine cycles later than an uninterrupted run.
        for (int c = 38; c <= 60; c++) begin
            step();
            chk_sched(cyc - 9);
        end

        // enable dropped mid-SETTLE: hop finishes, index advances, then IDLE.
        do_reset();
        set_tbl351();
        setup(2, 3, 5);
        start();
        for (int c = 1; c <= 8; c++) begin
            step();
            chk_sched(cyc);
            if (c == 2) enable = 1'b0;
        end
        for (int c = 9; c <= 12; c++) begin
            step();
            chk_idle("drop", 3'd3, 3'd1);
        end

        // Rewrite the active entry, then shrink cfg_len below the current index.
        do_reset();
        set_tbl351();
        setup(2, 1, 2);
        start();
        step();
        chk_sched(cyc);
        wr(0, 7);
        chk("wr_hold2", 64'(profile_o), 64'd3);
        step();
        chk("wr_hold3", 64'(profile_o), 64'd3);
        m_tbl[0] = 3'd7;
        for (int c = 4; c <= 13; c++) begin
            step();
            chk_sched(cyc);
        end
        cfg_len = 3'd0;
        for (int c = 14; c <= 15; c++) begin
            step();
            chk_sched(cyc);
        end
        for (int c = 16; c <= 22; c++) begin
            step();
            chk("shrink_profile", 64'(profile_o),   64'd7);
            chk("shrink_idx",     64'(hop_index_o), 64'd0);
            chk("shrink_hop",     64'(hop_o),       ((c - 16) % 3 == 0) ? 64'd1 : 64'd0);
        end

        // Asynchronous reset mid-DWELL clears outputs and the table at once.
        do_reset();
        set_tbl351();
        setup(2, 2, 6);
        start();
        for (int c = 1; c <= 5; c++) begin
            step();
            chk_sched(cyc);
        end
        #3;
        resetn = 1'b0;
        #1;
        chk_idle("async", 3'd0, 3'd0);
        @(posedge clk);
        #1;
        enable = 1'b0;
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_idle("post_rst", 3'd0, 3'd0);
        end
        for (int i = 0; i < 8; i++) m_tbl[i] = 3'd0;
        start();
        for (int c = 1; c <= 8; c++) begin
            step();
            chk_sched(cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fastlock_hop_scheduler.md
# fastlock_hop_scheduler

Sequences the AD936x fast-lock profile select pins (CTRL_IN1..CTRL_IN3) through a programmable hop table, with per-hop settle and dwell timing. It replaces free-running profile cycling with a scheduled, software-configured hop plan. It also arbitrates a single manual-override requester against the running schedule. It drives the same 64-bit GPIO word the transceiver control path already consumes, placing the profile field at bit PROFILE_SHIFT.

## Interface
- PROFILE_SHIFT, 9, LSB position of the 3-bit profile field in gpio_o (CTRL_IN1 mapping)
- CNT_W, 32, width of the dwell/settle counters

- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset; one clock domain only
- cfg_we  in  1  write strobe for the hop table
- cfg_addr  in  3  hop table entry index
- cfg_profile  in  3  profile value written to entry cfg_addr
- cfg_len  in  3  last valid table index (schedule length = cfg_len+1)
- dwell_cycles  in  CNT_W  cycles settled_o stays high per hop; 0 treated as 1
- settle_cycles  in  CNT_W  cycles after a profile change before settled_o; 0 treated as 1
- enable  in  1  level; schedule runs while high
- ovr_req  in  1  override request (level, held until ack, released when done)
- ovr_profile  in  3  override profile; sampled at grant
- ovr_ack  out  1  override granted and settled
- gpio_o  out  64  profile << PROFILE_SHIFT, all other bits 0
- profile_o  out  3  current profile
- hop_o  out  1  one-cycle pulse on the cycle profile_o/gpio_o change
- settled_o  out  1  high during DWELL and OVR_HOLD
- hop_index_o  out  3  table index of current scheduled hop
- busy_o  out  1  high in any state other than IDLE

## Operation
- Hop table: 8 x 3-bit registers, written on cfg_we in any state. A write becomes visible the next time that entry is loaded. A write to the entry currently active does not change profile_o.
- States: IDLE, SETTLE, DWELL, OVR_SETTLE, OVR_HOLD, OVR_REL.
- Hop boundary: leaving IDLE, the end of DWELL, or OVR_REL. At a boundary the priority is ovr_req, then enable, then go to IDLE.
- IDLE: profile held. If ovr_req: go to OVR_SETTLE. Else if enable: load table[hop_index_o] and go to SETTLE.
- SETTLE: counter loaded with max(settle_cycles,1)-1, sampled at load. Go to DWELL when the counter reaches 0.
- DWELL: counter loaded with max(dwell_cycles,1)-1. At the end, hop_index_o advances: it wraps to 0 when it equals cfg_len or exceeds cfg_len (cfg_len shrunk mid-run). The boundary rule then applies.
- Override: OVR_SETTLE loads profile=ovr_profile and counts settle like SETTLE, then goes to OVR_HOLD.
  - OVR_HOLD: ovr_ack=1 while ovr_req=1. When ovr_req=0: go to OVR_REL and clear ack.
  - OVR_REL lasts one cycle and acts as a boundary, so the schedule resumes at hop_index_o (not advanced). A new ovr_req seen here re-enters override.
- enable falling is graceful: the current SETTLE/DWELL completes, the index advances, then the block goes to IDLE. The last profile is held on gpio_o.
- hop_o pulses only when a new profile is loaded, even if the value is unchanged. It does not pulse on entering IDLE.
- Counters are CNT_W unsigned. No overflow is possible since the load is ≤ 2^CNT_W-1.

## Timing
- Reset (async assert, sync-safe deassert): all outputs 0, table entries 0, hop_index_o=0, state IDLE.
- enable rises at cycle N (registered): profile_o/gpio_o/hop_o update at N+1, busy_o=1 at N+1.
- SETTLE length = max(settle_cycles,1) cycles. settled_o rises on the first DWELL cycle.
- DWELL length = max(dwell_cycles,1) cycles. The next profile appears on the cycle after the last DWELL cycle, with settled_o=0 on that cycle.
- Hop period = max(settle,1)+max(dwell,1) cycles exactly, with no idle gap.
- ovr_req seen mid-DWELL waits for the hop boundary, so the maximum grant latency is one dwell.
- ovr_ack rises with settled_o on the first OVR_HOLD cycle. ovr_ack falls the cycle after ovr_req is seen low.

## Test plan
- Table {3,5,1}, cfg_len=2, settle=4, dwell=10, enable high: profile_o goes 3,5,1,3 with hops every 14 cycles. gpio_o=profile<<9. hop_o has one pulse per hop. settled_o is high for 10 of every 14 cycles.
- settle=0, dwell=0: profile changes every 2 cycles and settled_o alternates each cycle.
- ovr_req with ovr_profile=6 during DWELL of index 1: the grant occurs at the end of that dwell and profile becomes 6. ovr_ack rises after settle. Release leads to resuming at index 2 after the OVR_REL cycle.
- enable dropped mid-SETTLE: the current hop completes settle and dwell, then the block goes to IDLE with busy_o=0, the profile held, and hop_index_o advanced.
- Write table[0]=7 while at index 0: profile_o is unchanged until index 0 next loads, then shows 7. Shrinking cfg_len below the current index wraps to 0.
- resetn asserted mid-DWELL: all outputs are 0 immediately (asynchronously). After release the block stays in IDLE until enable or ovr_req.
